// File: rtl/cmd_sequencer_pkg.sv
// Shared types and constants for the command sequencer: FSM states, opcode
// values, response bytes and the opcode classifier used by the dispatcher.
package cmd_pkg;

   localparam int CMD_W    = 16;
   localparam int OPCODE_W = 4;
   localparam int ARG_W    = 12;
   localparam int RESP_W   = 8;

   localparam int                DEF_TIMEOUT_CYC = 65536;
   localparam logic [RESP_W-1:0] DEF_ACK         = 8'hA5;
   localparam logic [RESP_W-1:0] DEF_NAK         = 8'h5A;
   localparam logic [RESP_W-1:0] DEF_TMO         = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DISPATCH,
      ST_WAIT_OP,
      ST_RESP,
      ST_WAIT_SENT
   } state_e;

   typedef enum logic [OPCODE_W-1:0] {
      OP_NOP           = 4'h0,
      OP_FIRST_VALID   = 4'h1,
      OP_LAST_VALID    = 4'h7,
      OP_FIRST_ILLEGAL = 4'h8
   } opcode_e;

   typedef enum logic [1:0] {
      CLS_NOP,
      CLS_OPERATION,
      CLS_ILLEGAL
   } op_class_e;

   // Opcodes 1..7 launch a datapath operation; everything above 7 is rejected.
   function automatic op_class_e classify_opcode(input logic [OPCODE_W-1:0] opcode);
      op_class_e cls;
      if (opcode == OP_NOP) begin
         cls = CLS_NOP;
      end else if (opcode <= OP_LAST_VALID) begin
         cls = CLS_OPERATION;
      end else begin
         cls = CLS_ILLEGAL;
      end
      return cls;
   endfunction

endpackage

// File: rtl/cmd_sequencer_op_timer.sv
// Saturating watchdog counter that bounds how long the sequencer waits for
// the datapath to report op_done.
module op_timer #(
   parameter int TIMEOUT_CYC = 65536
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int               CNT_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT_CYC - 2);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CNT_LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Flags the cycle in which the count steps onto TIMEOUT_CYC-1.
   assign expired = enable && !clear && (count_q == CNT_EXPIRE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: takes 16-bit commands from the UART wrapper, dispatches
// them to the datapath and returns a one-byte ACK/NAK/timeout response.
module cmd_sequencer
   import cmd_pkg::*;
#(
   parameter int                TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter logic [RESP_W-1:0] ACK         = DEF_ACK,
   parameter logic [RESP_W-1:0] NAK         = DEF_NAK,
   parameter logic [RESP_W-1:0] TMO         = DEF_TMO
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_rdy,
   input  logic [CMD_W-1:0]    cmd,
   output logic                clr_cmd_rdy,
   output logic                op_start,
   output logic [OPCODE_W-1:0] op_code,
   output logic [ARG_W-1:0]    op_arg,
   input  logic                op_done,
   output logic                send_resp,
   output logic [RESP_W-1:0]   resp,
   input  logic                resp_sent,
   output logic                busy
);

   state_e              state_q, state_d;
   logic [OPCODE_W-1:0] op_code_q, op_code_d;
   logic [ARG_W-1:0]    op_arg_q, op_arg_d;
   logic [RESP_W-1:0]   resp_q, resp_d;
   logic                clr_cmd_rdy_q, clr_cmd_rdy_d;
   logic                op_start_q, op_start_d;
   logic                send_resp_q, send_resp_d;
   logic                busy_q, busy_d;

   logic timer_clear;
   logic timer_enable;
   logic timer_expired;

   // Timer controls depend only on the current state, keeping expired loop-free.
   assign timer_clear  = (state_q == ST_DISPATCH);
   assign timer_enable = (state_q == ST_WAIT_OP);

   op_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_op_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (timer_clear),
      .enable (timer_enable),
      .expired(timer_expired)
   );

   always_comb begin
      state_d       = state_q;
      op_code_d     = op_code_q;
      op_arg_d      = op_arg_q;
      resp_d        = resp_q;
      clr_cmd_rdy_d = 1'b0;
      op_start_d    = 1'b0;
      send_resp_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_rdy) begin
               op_code_d     = cmd[CMD_W-1:ARG_W];
               op_arg_d      = cmd[ARG_W-1:0];
               clr_cmd_rdy_d = 1'b1;
               state_d       = ST_DISPATCH;
            end
         end

         ST_DISPATCH: begin
            unique case (classify_opcode(op_code_q))
               CLS_NOP: begin
                  resp_d  = ACK;
                  state_d = ST_RESP;
               end
               CLS_OPERATION: begin
                  op_start_d = 1'b1;
                  state_d    = ST_WAIT_OP;
               end
               default: begin
                  resp_d  = NAK;
                  state_d = ST_RESP;
               end
            endcase
         end

         // A completion arriving on the timeout cycle still counts as success.
         ST_WAIT_OP: begin
            if (op_done) begin
               resp_d  = ACK;
               state_d = ST_RESP;
            end else if (timer_expired) begin
               resp_d  = TMO;
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            send_resp_d = 1'b1;
            state_d     = ST_WAIT_SENT;
         end

         ST_WAIT_SENT: begin
            if (resp_sent) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         op_code_q     <= '0;
         op_arg_q      <= '0;
         resp_q        <= '0;
         clr_cmd_rdy_q <= 1'b0;
         op_start_q    <= 1'b0;
         send_resp_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_code_q     <= op_code_d;
         op_arg_q      <= op_arg_d;
         resp_q        <= resp_d;
         clr_cmd_rdy_q <= clr_cmd_rdy_d;
         op_start_q    <= op_start_d;
         send_resp_q   <= send_resp_d;
         busy_q        <= busy_d;
      end
   end

   assign clr_cmd_rdy = clr_cmd_rdy_q;
   assign op_start    = op_start_q;
   assign op_code     = op_code_q;
   assign op_arg      = op_arg_q;
   assign send_resp   = send_resp_q;
   assign resp        = resp_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: fixed vector table, hand-written
// multi-cycle sequences and random commands against a transaction-level model.
module tb_cmd_sequencer;

   localparam int TimeoutCyc = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_rdy;
   logic [15:0] cmd;
   logic        clr_cmd_rdy;
   logic        op_start;
   logic [3:0]  op_code;
   logic [11:0] op_arg;
   logic        op_done;
   logic        send_resp;
   logic [7:0]  resp;
   logic        resp_sent;
   logic        busy;

   int vectorCount = 0;
   int missCount   = 0;

   cmd_sequencer #(
      .TIMEOUT_CYC(TimeoutCyc)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_rdy    (cmd_rdy),
      .cmd        (cmd),
      .clr_cmd_rdy(clr_cmd_rdy),
      .op_start   (op_start),
      .op_code    (op_code),
      .op_arg     (op_arg),
      .op_done    (op_done),
      .send_resp  (send_resp),
      .resp       (resp),
      .resp_sent  (resp_sent),
      .busy       (busy)
   );

   // Free-running clock; all driving and sampling happens on the falling edge.
   always #5 clk = ~clk;

   // One command: op_done is driven doneDelay cycles after cycle 2 (-1 = never);
   // expected latency counts cycles from the cmd_rdy cycle to send_resp.
   typedef struct {
      logic [15:0] cmdWord;
      int          doneDelay;
      logic [7:0]  expResp;
      bit          expStart;
      int          expLatency;
   } vector_t;

   typedef struct {
      bit          finished;
      int          clrCycle;
      int          clrCount;
      int          startCycle;
      int          startCount;
      int          respCycle;
      int          sendCount;
      logic [3:0]  opCode;
      logic [11:0] opArg;
      logic [7:0]  respByte;
      bit          respUnstable;
      logic        busyAfter;
   } result_t;

   vector_t vectors[10];

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Transaction-level reference: response and timing derived from opcode class and op duration.
   function automatic vector_t refModel(input logic [15:0] c, input int d);
      vector_t v;
      v.cmdWord   = c;
      v.doneDelay = d;
      if (c[15:12] == 4'h0) begin
         v.expResp = 8'hA5; v.expStart = 1'b0; v.expLatency = 3;
      end else if (c[15:12] >= 4'h8) begin
         v.expResp = 8'h5A; v.expStart = 1'b0; v.expLatency = 3;
      end else begin
         v.expStart = 1'b1;
         if (d >= 0 && (d + 1) < TimeoutCyc) begin
            v.expResp = 8'hA5; v.expLatency = 3 + (d + 1);
         end else begin
            v.expResp = 8'hEE; v.expLatency = 2 + TimeoutCyc;
         end
      end
      return v;
   endfunction

   // Drives one command like the UART wrapper/datapath/transmitter would and records what happened.
   task automatic applyStimulus(input logic [15:0] cmdWord, input int doneDelay, output result_t r);
      int sentAt;
      r.finished = 1'b0; r.clrCycle = -1; r.clrCount = 0; r.startCycle = -1; r.startCount = 0;
      r.respCycle = -1; r.sendCount = 0; r.opCode = '0; r.opArg = '0; r.respByte = '0;
      r.respUnstable = 1'b0; r.busyAfter = 1'b1;
      sentAt = -1;
      @(negedge clk);
      cmd     = cmdWord;
      cmd_rdy = 1'b1;
      for (int t = 1; t <= 200 && !r.finished; t++) begin
         @(negedge clk);
         op_done   = 1'b0;
         resp_sent = 1'b0;
         if (clr_cmd_rdy) begin
            r.clrCount++;
            if (r.clrCycle < 0) begin
               r.clrCycle = t; r.opCode = op_code; r.opArg = op_arg;
            end
            cmd_rdy = 1'b0;
         end
         if (op_start) begin
            r.startCount++;
            if (r.startCycle < 0) r.startCycle = t;
         end
         if (doneDelay >= 0 && t == 2 + doneDelay) op_done = 1'b1;
         if (send_resp) begin
            r.sendCount++;
            if (r.respCycle < 0) begin
               r.respCycle = t; r.respByte = resp; sentAt = t + 3;
            end
         end else if (r.respCycle >= 0 && resp !== r.respByte) begin
            r.respUnstable = 1'b1;
         end
         if (t == sentAt) resp_sent = 1'b1;
         if (sentAt >= 0 && t == sentAt + 1) begin
            r.busyAfter = busy;
            r.finished  = 1'b1;
         end
      end
      op_done   = 1'b0;
      resp_sent = 1'b0;
      cmd_rdy   = 1'b0;
   endtask

   task automatic checkVector(input string tag, input vector_t v, input result_t r);
      checkOutput($sformatf("%s completed", tag), 32'(r.finished), 1);
      checkOutput($sformatf("%s clr_cmd_rdy cycle", tag), r.clrCycle, 1);
      checkOutput($sformatf("%s clr_cmd_rdy pulses", tag), r.clrCount, 1);
      checkOutput($sformatf("%s op_code", tag), 32'(r.opCode), 32'(v.cmdWord[15:12]));
      checkOutput($sformatf("%s op_arg", tag), 32'(r.opArg), 32'(v.cmdWord[11:0]));
      checkOutput($sformatf("%s op_start pulses", tag), r.startCount, v.expStart ? 1 : 0);
      if (v.expStart) checkOutput($sformatf("%s op_start cycle", tag), r.startCycle, 2);
      checkOutput($sformatf("%s resp", tag), 32'(r.respByte), 32'(v.expResp));
      checkOutput($sformatf("%s send_resp cycle", tag), r.respCycle, v.expLatency);
      checkOutput($sformatf("%s send_resp pulses", tag), r.sendCount, 1);
      checkOutput($sformatf("%s resp stable", tag), 32'(r.respUnstable), 0);
      checkOutput($sformatf("%s busy after resp_sent", tag), 32'(r.busyAfter), 0);
   endtask

   initial begin
      result_t     res;
      vector_t     v;
      int          clrCycles[$];
      int          sendCycles[$];
      logic [7:0]  sendBytes[$];
      logic        respChanged;
      logic        busyAt17;
      logic [3:0]  codeMid;
      logic [11:0] argMid;
      logic [3:0]  codeSecond;
      int          strayCount;

      vectors[0] = '{16'h0000, -1, 8'hA5, 1'b0, 3};
      vectors[1] = '{16'h3ABC, 10, 8'hA5, 1'b1, 14};
      vectors[2] = '{16'h9123, -1, 8'h5A, 1'b0, 3};
      vectors[3] = '{16'h2001, -1, 8'hEE, 1'b1, 18};
      vectors[4] = '{16'h7FFF,  0, 8'hA5, 1'b1, 4};
      vectors[5] = '{16'h1005, 14, 8'hA5, 1'b1, 18};
      vectors[6] = '{16'h1006, 15, 8'hEE, 1'b1, 18};
      vectors[7] = '{16'hF000, -1, 8'h5A, 1'b0, 3};
      vectors[8] = '{16'h8000,  0, 8'h5A, 1'b0, 3};
      vectors[9] = '{16'h0FFF,  1, 8'hA5, 1'b0, 3};

      rst_n = 1'b1; cmd_rdy = 1'b0; cmd = '0; op_done = 1'b0; resp_sent = 1'b0;
      #2 rst_n = 1'b0;
      cmd_rdy = 1'b1; cmd = 16'h3FFF; op_done = 1'b1; resp_sent = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset resp", 32'(resp), 0);
      checkOutput("reset clr_cmd_rdy", 32'(clr_cmd_rdy), 0);
      checkOutput("reset op_start", 32'(op_start), 0);
      checkOutput("reset send_resp", 32'(send_resp), 0);
      checkOutput("reset op_code", 32'(op_code), 0);
      checkOutput("reset op_arg", 32'(op_arg), 0);
      cmd_rdy = 1'b0; cmd = '0; op_done = 1'b0; resp_sent = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle busy", 32'(busy), 0);

      $display("[TB] table vectors");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vectors[i].cmdWord, vectors[i].doneDelay, res);
         checkVector($sformatf("vec%0d", i), vectors[i], res);
      end

      $display("[TB] second command while busy");
      respChanged = 1'b0; busyAt17 = 1'b1; codeMid = '0; argMid = '0; codeSecond = '0;
      @(negedge clk);
      cmd = 16'h3ABC; cmd_rdy = 1'b1;
      for (int t = 1; t <= 24; t++) begin
         @(negedge clk);
         op_done = 1'b0; resp_sent = 1'b0;
         if (clr_cmd_rdy) begin
            clrCycles.push_back(t);
            cmd_rdy = 1'b0;
         end
         if (t == 5) begin
            cmd = 16'h8123; cmd_rdy = 1'b1;
         end
         if (t == 12) begin
            op_done = 1'b1; codeMid = op_code; argMid = op_arg;
         end
         if (send_resp) begin
            sendCycles.push_back(t); sendBytes.push_back(resp);
         end
         if (t > 14 && t <= 16 && resp !== 8'hA5) respChanged = 1'b1;
         if (t == 16 || t == 22) resp_sent = 1'b1;
         if (t == 17) busyAt17 = busy;
         if (t == 18) codeSecond = op_code;
      end
      op_done = 1'b0; resp_sent = 1'b0; cmd_rdy = 1'b0;
      checkOutput("queued clr count", clrCycles.size(), 2);
      checkOutput("queued first clr", (clrCycles.size() > 0) ? clrCycles[0] : -1, 1);
      checkOutput("queued second clr", (clrCycles.size() > 1) ? clrCycles[1] : -1, 18);
      checkOutput("queued op_code mid-op", 32'(codeMid), 32'h3);
      checkOutput("queued op_arg mid-op", 32'(argMid), 32'hABC);
      checkOutput("queued send count", sendCycles.size(), 2);
      checkOutput("queued first send cycle", (sendCycles.size() > 0) ? sendCycles[0] : -1, 14);
      checkOutput("queued first resp", (sendBytes.size() > 0) ? 32'(sendBytes[0]) : 32'hFFFF, 32'hA5);
      checkOutput("queued resp stable", 32'(respChanged), 0);
      checkOutput("queued busy in idle", 32'(busyAt17), 0);
      checkOutput("queued second op_code", 32'(codeSecond), 32'h8);
      checkOutput("queued second send cycle", (sendCycles.size() > 1) ? sendCycles[1] : -1, 20);
      checkOutput("queued second resp", (sendBytes.size() > 1) ? 32'(sendBytes[1]) : 32'hFFFF, 32'h5A);

      $display("[TB] reset during WAIT_OP");
      @(negedge clk);
      cmd = 16'h2001; cmd_rdy = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         @(negedge clk);
         if (clr_cmd_rdy) cmd_rdy = 1'b0;
      end
      checkOutput("pre-reset busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midop reset busy", 32'(busy), 0);
      checkOutput("midop reset resp", 32'(resp), 0);
      checkOutput("midop reset op_code", 32'(op_code), 0);
      checkOutput("midop reset op_arg", 32'(op_arg), 0);
      checkOutput("midop reset op_start", 32'(op_start), 0);
      checkOutput("midop reset send_resp", 32'(send_resp), 0);
      checkOutput("midop reset clr_cmd_rdy", 32'(clr_cmd_rdy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      strayCount = 0;
      for (int t = 0; t < 25; t++) begin
         @(negedge clk);
         if (send_resp || op_start || busy) strayCount++;
      end
      checkOutput("no activity after reset", strayCount, 0);

      $display("[TB] random commands");
      for (int i = 0; i < 40; i++) begin
         logic [15:0] c;
         int          d;
         c = 16'($urandom);
         d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TimeoutCyc + 2));
         v = refModel(c, d);
         applyStimulus(c, d, res);
         checkVector($sformatf("rnd%0d cmd=%h d=%0d", i, c, d), v, res);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
